// File: rtl/cmult_rr_arbiter.sv
// Round-robin arbiter that shares one complex multiplier among nreq requesters.
// One transaction is in flight at a time; operands and results pass through unmodified.
module cmult_rr_arbiter #(
  parameter int n    = 32,
  parameter int d    = 16,
  parameter int nreq = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [nreq-1:0]         req_val,
  output logic [nreq-1:0]         req_rdy,
  input  logic [nreq*n-1:0]       req_ar,
  input  logic [nreq*n-1:0]       req_ac,
  input  logic [nreq*n-1:0]       req_br,
  input  logic [nreq*n-1:0]       req_bc,
  output logic [nreq-1:0]         resp_val,
  input  logic [nreq-1:0]         resp_rdy,
  output logic [n-1:0]            resp_cr,
  output logic [n-1:0]            resp_cc,
  output logic                    m_recv_val,
  input  logic                    m_recv_rdy,
  input  logic                    m_send_val,
  output logic                    m_send_rdy,
  output logic [n-1:0]            m_ar,
  output logic [n-1:0]            m_ac,
  output logic [n-1:0]            m_br,
  output logic [n-1:0]            m_bc,
  input  logic [n-1:0]            m_cr,
  input  logic [n-1:0]            m_cc,
  output logic                    busy,
  output logic [$clog2(nreq)-1:0] owner
);

  localparam int OW = $clog2(nreq);

  if (nreq < 2 || (nreq & (nreq - 1)) != 0) begin : g_bad_nreq
    $error("cmult_rr_arbiter: nreq must be a power of two, at least 2");
  end
  if (d < 0 || d >= n) begin : g_bad_d
    $error("cmult_rr_arbiter: d must lie in [0, n)");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [n-1:0]  ar_q, ar_d, ac_q, ac_d, br_q, br_d, bc_q, bc_d;
  logic [n-1:0]  cr_q, cr_d, cc_q, cc_d;

  logic          win_found;
  logic [OW-1:0] win_idx;
  logic [OW-1:0] cand;
  int            sel_base;

  // Search upward from ptr; the OW-bit sum wraps nreq-1 back to 0 for free.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < nreq; i++) begin
      cand = ptr_q + OW'(i);
      if (!win_found && req_val[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    sel_base = int'(win_idx) * n;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    ar_d       = ar_q;
    ac_d       = ac_q;
    br_d       = br_q;
    bc_d       = bc_q;
    cr_d       = cr_q;
    cc_d       = cc_q;
    req_rdy    = '0;
    resp_val   = '0;
    m_recv_val = 1'b0;
    m_send_rdy = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The grant is the handshake: req_rdy is raised only when req_val is already high.
        if (win_found && !reset) begin
          req_rdy[win_idx] = 1'b1;
          owner_d          = win_idx;
          ar_d             = req_ar[sel_base +: n];
          ac_d             = req_ac[sel_base +: n];
          br_d             = req_br[sel_base +: n];
          bc_d             = req_bc[sel_base +: n];
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        m_recv_val = 1'b1;
        if (m_recv_rdy) state_d = WAIT;
      end
      WAIT: begin
        m_send_rdy = 1'b1;
        if (m_send_val) begin
          cr_d    = m_cr;
          cc_d    = m_cc;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_val[owner_q] = 1'b1;
        if (resp_rdy[owner_q]) begin
          ptr_d   = owner_q + OW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      ar_q    <= '0;
      ac_q    <= '0;
      br_q    <= '0;
      bc_q    <= '0;
      cr_q    <= '0;
      cc_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      ar_q    <= ar_d;
      ac_q    <= ac_d;
      br_q    <= br_d;
      bc_q    <= bc_d;
      cr_q    <= cr_d;
      cc_q    <= cc_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign owner   = owner_q;
  assign m_ar    = ar_q;
  assign m_ac    = ac_q;
  assign m_br    = br_q;
  assign m_bc    = bc_q;
  assign resp_cr = cr_q;
  assign resp_cc = cc_q;

endmodule

// File: tb/tb_cmult_rr_arbiter.sv
// Scoreboard bench for cmult_rr_arbiter, backed by a Q16.16 complex multiplier model.
module tb_cmult_rr_arbiter;

  localparam int N  = 32;
  localparam int D  = 16;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NR-1:0]   req_val;
  logic [NR-1:0]   req_rdy;
  logic [NR*N-1:0] req_ar, req_ac, req_br, req_bc;
  logic [NR-1:0]   resp_val;
  logic [NR-1:0]   resp_rdy;
  logic [N-1:0]    resp_cr, resp_cc;
  logic            m_recv_val, m_recv_rdy, m_send_val, m_send_rdy;
  logic [N-1:0]    m_ar, m_ac, m_br, m_bc, m_cr, m_cc;
  logic            busy;
  logic [1:0]      owner;

  cmult_rr_arbiter #(.n(N), .d(D), .nreq(NR)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy),
    .req_ar(req_ar), .req_ac(req_ac), .req_br(req_br), .req_bc(req_bc),
    .resp_val(resp_val), .resp_rdy(resp_rdy),
    .resp_cr(resp_cr), .resp_cc(resp_cc),
    .m_recv_val(m_recv_val), .m_recv_rdy(m_recv_rdy),
    .m_send_val(m_send_val), .m_send_rdy(m_send_rdy),
    .m_ar(m_ar), .m_ac(m_ac), .m_br(m_br), .m_bc(m_bc),
    .m_cr(m_cr), .m_cc(m_cc),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Q16.16 complex multiplier with a two-cycle compute delay, sharing the DUT reset.
  function automatic logic [31:0] fxMul(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] e,
                                        input logic sub);
    logic signed [63:0] p;
    logic signed [63:0] q;
    logic signed [63:0] s;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    q = $signed({{32{c[31]}}, c}) * $signed({{32{e[31]}}, e});
    s = sub ? (p - q) : (p + q);
    return s[47:16];
  endfunction

  logic        mbBusy;
  logic [1:0]  mbCnt;
  logic [31:0] mbCr, mbCc;

  assign m_recv_rdy = !mbBusy;
  assign m_send_val = mbBusy && (mbCnt == 2'd0);
  assign m_cr       = mbCr;
  assign m_cc       = mbCc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mbBusy <= 1'b0;
      mbCnt  <= 2'd0;
      mbCr   <= 32'd0;
      mbCc   <= 32'd0;
    end else if (!mbBusy) begin
      if (m_recv_val) begin
        mbBusy <= 1'b1;
        mbCnt  <= 2'd2;
        mbCr   <= fxMul(m_ar, m_br, m_ac, m_bc, 1'b1);
        mbCc   <= fxMul(m_ar, m_bc, m_ac, m_br, 1'b0);
      end
    end else if (mbCnt != 2'd0) begin
      mbCnt <= mbCnt - 2'd1;
    end else if (m_send_rdy) begin
      mbBusy <= 1'b0;
    end
  end

  typedef struct {
    int          idx;
    logic [31:0] cr;
    logic [31:0] cc;
  } exp_t;

  exp_t        expQ[$];
  int          grantLog[$];
  int          nCompared = 0;
  int          nMismatched = 0;
  int          inflight = 0;
  logic [3:0]  keepMask = 4'b0000;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] ar, input logic [31:0] ac,
                               input logic [31:0] br, input logic [31:0] bc);
    req_ar[idx*N +: N] = ar;
    req_ac[idx*N +: N] = ac;
    req_br[idx*N +: N] = br;
    req_bc[idx*N +: N] = bc;
    req_val[idx]       = 1'b1;
  endtask

  task automatic pushExpect(input int idx, input logic [31:0] cr, input logic [31:0] cc);
    exp_t e;
    e.idx = idx;
    e.cr  = cr;
    e.cc  = cc;
    expQ.push_back(e);
  endtask

  // One clock; a requester that was granted drops req_val unless it is held in keepMask.
  task automatic tick();
    logic [3:0] acc;
    @(negedge clk);
    acc = req_val & req_rdy;
    @(posedge clk);
    #1;
    req_val = req_val & ~(acc & ~keepMask);
  endtask

  task automatic waitDone(input string name, input int budget);
    int c = 0;
    while ((expQ.size() != 0 || busy || req_val != 4'b0) && c < budget) begin
      tick();
      c++;
    end
    checkOutput({name, "_done"}, 32'(c < budget), 32'd1);
  endtask

  // Monitor: reset checks, grant invariants, and scoreboard pops on each response handshake.
  initial begin
    exp_t e;
    int   g;
    int   r;
    forever begin
      @(negedge clk);
      if (reset) begin
        inflight = 0;
        checkOutput("rst_ctrl_outs",
                    32'({req_rdy, resp_val, m_recv_val, m_send_rdy, busy, owner}), 32'd0);
        checkOutput("rst_data_outs", resp_cr | resp_cc | m_ar | m_ac | m_br | m_bc, 32'd0);
      end else begin
        checkOutput("req_rdy_onehot0", 32'($onehot0(req_rdy)), 32'd1);
        checkOutput("rdy_while_busy", busy ? 32'(req_rdy) : 32'd0, 32'd0);
        if (|(req_val & req_rdy)) begin
          g = 0;
          for (int i = 0; i < NR; i++) if (req_val[i] && req_rdy[i]) g = i;
          grantLog.push_back(g);
          checkOutput("one_in_flight", 32'(inflight), 32'd0);
          inflight++;
        end
        if (|(resp_val & resp_rdy)) begin
          checkOutput("resp_onehot", 32'($onehot(resp_val)), 32'd1);
          checkOutput("resp_expected", 32'(expQ.size() != 0), 32'd1);
          if (expQ.size() != 0) begin
            e = expQ.pop_front();
            r = 0;
            for (int i = 0; i < NR; i++) if (resp_val[i]) r = i;
            checkOutput("resp_idx", 32'(r), 32'(e.idx));
            checkOutput("resp_cr", resp_cr, e.cr);
            checkOutput("resp_cc", resp_cc, e.cc);
          end
          inflight--;
        end
      end
    end
  end

  initial begin
    int c;
    req_val  = '0;
    resp_rdy = 4'hF;
    req_ar   = '0;
    req_ac   = '0;
    req_br   = '0;
    req_bc   = '0;
    #1 reset = 1'b1;

    // All four requesters valid out of reset: served 0,1,2,3.
    applyStimulus(0, 32'h0002_0000, 32'h0000_0000, 32'h0003_0000, 32'h0000_0000);
    applyStimulus(1, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 32'h0001_0000);
    applyStimulus(2, 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'h0000_0000);
    applyStimulus(3, 32'hFFFF_0000, 32'h0000_0000, 32'h0004_0000, 32'h0001_0000);
    pushExpect(0, 32'h0006_0000, 32'h0000_0000);
    pushExpect(1, 32'hFFFF_0000, 32'h0000_0000);
    pushExpect(2, 32'h0000_8000, 32'h0001_0000);
    pushExpect(3, 32'hFFFC_0000, 32'hFFFF_0000);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req_rdy_held", 32'(req_rdy), 32'd0);
    checkOutput("rst_busy_owner", 32'({busy, owner}), 32'd0);
    reset = 1'b0;
    waitDone("rr_all4", 200);
    checkOutput("rr_order_len", 32'(grantLog.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < grantLog.size()) checkOutput($sformatf("rr_order%0d", i), 32'(grantLog[i]), 32'(i));
    grantLog.delete();

    // Req0 and req2 held valid: grants alternate 0,2,0,2.
    keepMask = 4'b0101;
    applyStimulus(0, 32'h0001_8000, 32'h0000_0000, 32'h0002_0000, 32'h0000_0000);
    applyStimulus(2, 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'h0000_0000);
    pushExpect(0, 32'h0003_0000, 32'h0000_0000);
    pushExpect(2, 32'h0000_8000, 32'h0001_0000);
    pushExpect(0, 32'h0003_0000, 32'h0000_0000);
    pushExpect(2, 32'h0000_8000, 32'h0001_0000);
    c = 0;
    while (expQ.size() != 0 && c < 300) begin
      tick();
      c++;
    end
    req_val  = '0;
    keepMask = 4'b0000;
    checkOutput("alt_done", 32'(c < 300), 32'd1);
    waitDone("alt_settle", 50);
    checkOutput("alt_len", 32'(grantLog.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < grantLog.size())
        checkOutput($sformatf("alt_grant%0d", i), 32'(grantLog[i]), (i % 2 == 0) ? 32'd0 : 32'd2);
    grantLog.delete();

    // Single requests: 1.5*2 on req0, (1+1j)*(1+1j) on req1.
    applyStimulus(0, 32'h0001_8000, 32'h0000_0000, 32'h0002_0000, 32'h0000_0000);
    pushExpect(0, 32'h0003_0000, 32'h0000_0000);
    waitDone("req0_single", 100);
    applyStimulus(1, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    pushExpect(1, 32'h0000_0000, 32'h0002_0000);
    waitDone("req1_single", 100);

    // Owner stalls in RESP for 5 cycles while req1 waits; non-owner resp_rdy bits are high.
    resp_rdy = 4'b1110;
    applyStimulus(0, 32'h0001_8000, 32'h0000_0000, 32'h0002_0000, 32'h0000_0000);
    applyStimulus(1, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    pushExpect(0, 32'h0003_0000, 32'h0000_0000);
    pushExpect(1, 32'h0000_0000, 32'h0002_0000);
    tick();
    req_ar[0 +: N] = 32'hDEAD_BEEF;
    req_br[0 +: N] = 32'h1234_5678;
    checkOutput("issue_recv_val", 32'(m_recv_val), 32'd1);
    checkOutput("issue_m_ar", m_ar, 32'h0001_8000);
    checkOutput("issue_m_br", m_br, 32'h0002_0000);
    c = 0;
    while (!resp_val[0] && c < 100) begin
      tick();
      c++;
    end
    checkOutput("stall_reach_resp", 32'(resp_val[0]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_resp_val", 32'(resp_val), 32'd1);
      checkOutput("stall_resp_cr", resp_cr, 32'h0003_0000);
      checkOutput("stall_resp_cc", resp_cc, 32'h0000_0000);
      checkOutput("stall_req_rdy", 32'(req_rdy), 32'd0);
      checkOutput("stall_recv_val", 32'(m_recv_val), 32'd0);
      tick();
    end
    resp_rdy = 4'hF;
    waitDone("stall", 100);

    // Reset during WAIT abandons req2; a later req3-only request completes normally.
    applyStimulus(2, 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'h0000_0000);
    c = 0;
    while (!m_send_rdy && c < 100) begin
      tick();
      c++;
    end
    checkOutput("reach_wait", 32'(m_send_rdy), 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_ctrl",
                32'({req_rdy, resp_val, m_recv_val, m_send_rdy, busy, owner}), 32'd0);
    checkOutput("midrst_data", resp_cr | resp_cc | m_ar | m_ac | m_br | m_bc, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus(3, 32'hFFFF_0000, 32'h0000_0000, 32'h0004_0000, 32'h0001_0000);
    pushExpect(3, 32'hFFFC_0000, 32'hFFFF_0000);
    waitDone("after_reset", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/cmult_rr_arbiter.md
CMULT_RR_ARBITER -- requirements
Module: cmult_rr_arbiter

Interface
REQ-001 SHALL have parameter n, default 32, operand/result bit width.
REQ-002 SHALL have parameter d, default 16, fractional bits, passed through for documentation only; it does not alter this block's logic.
REQ-003 SHALL have parameter nreq, default 4, number of requesters; nreq is a power of two, minimum 2.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_val  input  nreq  per-requester operand valid.
REQ-007 SHALL have port req_rdy  output  nreq  per-requester operand accept.
REQ-008 SHALL have ports req_ar, req_ac, req_br, req_bc  input  nreq*n each  packed operands; requester i occupies bits [i*n +: n].
REQ-009 SHALL have port resp_val  output  nreq  per-requester result valid.
REQ-010 SHALL have port resp_rdy  input  nreq  per-requester result accept.
REQ-011 SHALL have ports resp_cr, resp_cc  output  n each  shared result bus, qualified by resp_val.
REQ-012 SHALL have ports m_recv_val (output, 1), m_recv_rdy (input, 1), m_send_val (input, 1), m_send_rdy (output, 1)  multiplier handshake.
REQ-013 SHALL have ports m_ar, m_ac, m_br, m_bc  output  n each  operands to the shared complex multiplier.
REQ-014 SHALL have ports m_cr, m_cc  input  n each  results from the shared complex multiplier.
REQ-015 SHALL have ports busy (output, 1) and owner (output, log2(nreq))  status signals.

Function
REQ-016 SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: when any req_val bit is set, SHALL select the winner by round-robin, searching upward from ptr with wrap from nreq-1 to 0.
REQ-018 IDLE: SHALL assert req_rdy only for the winner, combinationally in the same cycle.
REQ-019 IDLE acceptance: SHALL latch the winner's four operands and its index into owner, then move to ISSUE.
REQ-020 req_rdy SHALL be one-hot or zero every cycle; it SHALL be zero in every state except IDLE.
REQ-021 Operand changes after acceptance SHALL have no effect on the computation in flight.
REQ-022 ISSUE: m_recv_val SHALL be 1 and m_* operands SHALL show the latched values; on m_recv_rdy=1, the FSM SHALL move to WAIT.
REQ-023 WAIT: m_send_rdy SHALL be 1; on m_send_val=1, m_cr and m_cc SHALL be latched into the result registers and the FSM SHALL move to RESP.
REQ-024 m_send_rdy SHALL be 0 in every state except WAIT.
REQ-025 RESP: resp_val[owner] SHALL be 1, and resp_cr/resp_cc SHALL hold the latched results stable until the handshake.
REQ-026 RESP: on resp_rdy[owner]=1, ptr SHALL become (owner+1) mod nreq and the FSM SHALL move to IDLE.
REQ-027 resp_rdy bits of non-owners SHALL be ignored.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 Only one transaction SHALL be in flight; no new grant SHALL occur before the RESP handshake completes.
REQ-030 A requester that drops req_val before it is granted SHALL lose nothing and cause no side effect.
REQ-031 Minimum turnaround, excluding multiplier latency: 1 cycle ISSUE + 1 cycle RESP after the accept cycle.
REQ-032 The block SHALL perform no arithmetic; results SHALL pass through bit-exact at width n.

Reset
REQ-033 While reset=1, SHALL hold: FSM=IDLE, ptr=0, owner=0, operand and result registers=0.
REQ-034 While reset=1, all outputs (req_rdy, resp_val, m_recv_val, m_send_rdy, busy, resp_cr, resp_cc, m_*) SHALL be 0.
REQ-035 Reset asserted mid-transaction SHALL abandon the transaction with no response.
REQ-036 The multiplier shares this reset, so no stale m_send_val is expected after reset.
REQ-037 The first grant after reset SHALL be the lowest-index active requester.

Verification
REQ-038 The bench SHALL drive the multiplier port from a real fixed-point complex multiplier (n=32, d=16) and cover the scenarios REQ-039 to REQ-044.
REQ-039 Req0 ar=0x00018000, br=0x00020000, ac=bc=0 -> resp_val[0], cr=0x00030000, cc=0.
REQ-040 Req1 ar=ac=br=bc=0x00010000 -> resp_val[1], cr=0x00000000, cc=0x00020000.
REQ-041 All four req_val high from reset, each with a distinct operand set -> responses in order 0,1,2,3, each with the correct product, one in flight at a time.
REQ-042 Req0 and req2 continuously valid -> grants alternate 0,2,0,2; never two consecutive grants to the same requester.
REQ-043 resp_rdy[owner] held low 5 cycles in RESP -> resp_val and results stable, req_rdy=0 throughout, m_recv_val=0.
REQ-044 Reset pulsed during WAIT -> all outputs 0 within that cycle; a subsequent req3-only request is granted and returns the correct result.
